// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pipe_ctrl_state_e;

  localparam int REG_ZERO      = 0;
  localparam int DRAIN_CYC_DEF = 3;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs, pipeline-register controls and status between the datapath and pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              start;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rt;
  logic              id_halt;
  logic [REG_AW-1:0] ex_dest;
  logic              ex_wr;
  logic [REG_AW-1:0] mem_dest;
  logic              mem_wr;
  logic              ex_br_taken;

  logic              pc_en;
  logic              pc_sel;
  logic              if_id_en;
  logic              if_id_flush;
  logic              id_ex_bubble;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output start, id_rs, id_rt, id_uses_rt, id_halt,
           ex_dest, ex_wr, mem_dest, mem_wr, ex_br_taken,
    input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble,
           busy, done, stall_cnt, flush_cnt
  );

  modport slave (
    input  start, id_rs, id_rt, id_uses_rt, id_halt,
           ex_dest, ex_wr, mem_dest, mem_wr, ex_br_taken,
    output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble,
           busy, done, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_raw_detect.sv
// RAW match between the ID instruction's sources and one older writer's destination.
module raw_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] wr_dest,
  input  logic              wr_en,
  output logic              match
);

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // r0 is hardwired, so a write to it never creates a dependency
  assign dest_live = wr_en && (wr_dest != REG_AW'(REG_ZERO));
  assign rs_hit    = (wr_dest == id_rs);
  assign rt_hit    = id_uses_rt && (wr_dest == id_rt);
  assign match     = dest_live && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: start/halt FSM, RAW stall and taken-branch flush control, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int CNT_W     = 16
) (
  input logic         clk,
  input logic         reset,
  pipe_ctrl_if.slave  bus
);

  // state | meaning
  // IDLE  | stopped; all enables low, counters held
  // RUN   | fetching; stalls on RAW, flushes on taken branch, halt enters DRAIN
  // DRAIN | halt travelling EX->WB; front end frozen and bubbling
  // DONE  | one-cycle done pulse, then IDLE

  localparam int DW = $clog2(DRAIN_CYC + 1);

  pipe_ctrl_state_e state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ex_match;
  logic mem_match;
  logic haz;

  raw_detect #(.REG_AW(REG_AW)) u_raw_ex (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .wr_dest    (bus.ex_dest),
    .wr_en      (bus.ex_wr),
    .match      (ex_match)
  );

  raw_detect #(.REG_AW(REG_AW)) u_raw_mem (
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .id_uses_rt (bus.id_uses_rt),
    .wr_dest    (bus.mem_dest),
    .wr_en      (bus.mem_wr),
    .match      (mem_match)
  );

  assign haz = ex_match || mem_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    drain_d          = drain_q;
    stall_cnt_d      = stall_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    bus.pc_en        = 1'b0;
    bus.pc_sel       = 1'b0;
    bus.if_id_en     = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_bubble = 1'b0;
    bus.busy         = 1'b0;
    bus.done         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = RUN;
          stall_cnt_d = '0;
          flush_cnt_d = '0;
        end
      end

      RUN: begin
        bus.pc_en    = 1'b1;
        bus.if_id_en = 1'b1;
        bus.busy     = 1'b1;
        // a taken branch squashes whatever sits in ID, hazarded or halting
        if (bus.ex_br_taken) begin
          bus.pc_sel       = 1'b1;
          bus.if_id_flush  = 1'b1;
          bus.id_ex_bubble = 1'b1;
          if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end else if (haz) begin
          bus.pc_en        = 1'b0;
          bus.if_id_en     = 1'b0;
          bus.id_ex_bubble = 1'b1;
          if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (bus.id_halt) begin
          bus.pc_en       = 1'b0;
          bus.if_id_flush = 1'b1;
          drain_d         = DW'(DRAIN_CYC);
          state_d         = DRAIN;
        end
      end

      DRAIN: begin
        bus.if_id_flush  = 1'b1;
        bus.id_ex_bubble = 1'b1;
        bus.busy         = 1'b1;
        drain_d          = drain_q - DW'(1);
        if (drain_q == DW'(1)) state_d = DONE;
      end

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for RUN-cycle decisions plus halt/reset/saturation sequences.
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  pipe_ctrl_if #(.REG_AW(5), .CNT_W(16)) bus ();

  pipe_ctrl #(.REG_AW(5), .DRAIN_CYC(3), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_halt;
    logic [4:0] ex_dest;
    logic       ex_wr;
    logic [4:0] mem_dest;
    logic       mem_wr;
    logic       ex_br_taken;
    // expected {pc_en, pc_sel, if_id_en, if_id_flush, id_ex_bubble, busy}
    logic [5:0] exp_ctl;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.id_rs       = '0;
    bus.id_rt       = '0;
    bus.id_uses_rt  = 1'b0;
    bus.id_halt     = 1'b0;
    bus.ex_dest     = '0;
    bus.ex_wr       = 1'b0;
    bus.mem_dest    = '0;
    bus.mem_wr      = 1'b0;
    bus.ex_br_taken = 1'b0;
  endtask

  function automatic logic [5:0] ctl();
    return {bus.pc_en, bus.pc_sel, bus.if_id_en, bus.if_id_flush, bus.id_ex_bubble, bus.busy};
  endfunction

  int exp_stall;
  int exp_flush;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //            name          rs  rt uses halt exd exw memd memw br   pc sel ife fl bub busy
    vecs[0] = '{"ex_rs_haz",     5,  0, 0,   0,   5,  1,  0,   0,   0, 6'b000011};
    vecs[1] = '{"mem_rs_haz",    5,  0, 0,   0,   0,  0,  5,   1,   0, 6'b000011};
    vecs[2] = '{"r0_no_haz",     0,  0, 0,   0,   0,  1,  0,   0,   0, 6'b101001};
    vecs[3] = '{"rt_unused",     3,  7, 0,   0,   7,  1,  0,   0,   0, 6'b101001};
    vecs[4] = '{"mem_rt_haz",    3,  7, 1,   0,   0,  0,  7,   1,   0, 6'b000011};
    vecs[5] = '{"ex_nowr",       5,  0, 0,   0,   5,  0,  0,   0,   0, 6'b101001};
    vecs[6] = '{"br_over_all",   5,  0, 0,   1,   5,  1,  0,   0,   1, 6'b111111};
    vecs[7] = '{"halt_haz",      9,  0, 0,   1,   9,  1,  0,   0,   0, 6'b000011};
    vecs[8] = '{"mem_r0_rt",     4,  0, 1,   0,   0,  0,  0,   1,   0, 6'b101001};
    vecs[9] = '{"br_alone",      1,  2, 1,   0,   0,  0,  0,   0,   1, 6'b111111};

    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset_ctl",   int'(ctl()), 0);
    check("reset_done",  int'(bus.done), 0);
    check("reset_stall", int'(bus.stall_cnt), 0);
    check("reset_flush", int'(bus.flush_cnt), 0);

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      // a stray start while running must not clear anything
      bus.start = (i == 4);
      #1;
      check("clean_run_ctl", int'(ctl()), int'(6'b101001));
      tick();
    end
    bus.start = 1'b0;
    check("clean_stall", int'(bus.stall_cnt), 0);
    check("clean_flush", int'(bus.flush_cnt), 0);

    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 10; i++) begin
      bus.id_rs       = vecs[i].id_rs;
      bus.id_rt       = vecs[i].id_rt;
      bus.id_uses_rt  = vecs[i].id_uses_rt;
      bus.id_halt     = vecs[i].id_halt;
      bus.ex_dest     = vecs[i].ex_dest;
      bus.ex_wr       = vecs[i].ex_wr;
      bus.mem_dest    = vecs[i].mem_dest;
      bus.mem_wr      = vecs[i].mem_wr;
      bus.ex_br_taken = vecs[i].ex_br_taken;
      #1;
      check({vecs[i].name, "_ctl"}, int'(ctl()), int'(vecs[i].exp_ctl));
      check({vecs[i].name, "_done"}, int'(bus.done), 0);
      if (vecs[i].exp_ctl[5] == 1'b0) exp_stall++;
      if (vecs[i].exp_ctl[4] == 1'b1) exp_flush++;
      tick();
      idle_inputs();
      #1;
      check({vecs[i].name, "_stall_cnt"}, int'(bus.stall_cnt), exp_stall);
      check({vecs[i].name, "_flush_cnt"}, int'(bus.flush_cnt), exp_flush);
      check({vecs[i].name, "_still_run"}, int'(ctl()), int'(6'b101001));
    end

    // halt in a clean cycle: 3 drain cycles, done on the 4th
    bus.id_halt = 1'b1;
    #1;
    check("halt_ctl", int'(ctl()), int'(6'b001101));
    tick();
    bus.id_halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ex_br_taken = 1'b1;
      bus.start       = 1'b1;
      #1;
      check("drain_ctl",  int'(ctl()), int'(6'b000111));
      check("drain_done", int'(bus.done), 0);
      tick();
    end
    idle_inputs();
    #1;
    check("done_pulse", int'(bus.done), 1);
    check("done_ctl",   int'(ctl()), 0);
    check("drain_flush_cnt", int'(bus.flush_cnt), exp_flush);
    check("drain_stall_cnt", int'(bus.stall_cnt), exp_stall);
    tick();
    check("idle_done", int'(bus.done), 0);
    check("idle_ctl",  int'(ctl()), 0);
    tick();
    check("idle_hold_stall", int'(bus.stall_cnt), exp_stall);
    check("idle_hold_flush", int'(bus.flush_cnt), exp_flush);

    // restart clears counters; reset mid-drain aborts without done
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_stall", int'(bus.stall_cnt), 0);
    check("restart_flush", int'(bus.flush_cnt), 0);
    bus.ex_wr = 1'b1; bus.ex_dest = 5'd3; bus.id_rs = 5'd3;
    tick();
    idle_inputs();
    bus.ex_br_taken = 1'b1;
    tick();
    idle_inputs();
    bus.id_halt = 1'b1;
    tick();
    bus.id_halt = 1'b0;
    tick();
    #1;
    check("drain2_ctl", int'(ctl()), int'(6'b000111));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_done",  int'(bus.done), 0);
    check("abort_ctl",   int'(ctl()), 0);
    check("abort_stall", int'(bus.stall_cnt), 0);
    check("abort_flush", int'(bus.flush_cnt), 0);
    tick();
    check("abort_no_done", int'(bus.done), 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    #1;
    check("after_abort_run", int'(ctl()), int'(6'b101001));

    // hold a hazard long enough to saturate the stall counter
    bus.ex_wr = 1'b1; bus.ex_dest = 5'd12; bus.id_rt = 5'd12; bus.id_uses_rt = 1'b1;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("stall_sat", int'(bus.stall_cnt), 65535);
    check("stall_sat_ctl", int'(ctl()), int'(6'b000011));
    idle_inputs();
    tick();
    check("stall_sat_hold", int'(bus.stall_cnt), 65535);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline. It starts and halts program execution and detects RAW hazards between the instruction in ID and older writers in EX/MEM; the datapath has no forwarding. It issues the stall, bubble and flush controls that drive the PC, IF/ID and ID/EX registers, and counts stall and flush cycles for the testbench.

Parameters:
REG_AW, 5, register-address width (matches ADDR_LINE_REG).
DRAIN_CYC, 3, cycles after a halt leaves ID until it retires from WB.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  one-cycle pulse; begin execution from IDLE.
id_rs  in  REG_AW  rs address of the instruction in ID.
id_rt  in  REG_AW  rt address of the instruction in ID.
id_uses_rt  in  1  the ID instruction reads rt (R-type, store, branch).
id_halt  in  1  the ID instruction is HALT.
ex_dest  in  REG_AW  destination address of the instruction in EX.
ex_wr  in  1  the EX instruction writes the register file.
mem_dest  in  REG_AW  destination address of the instruction in MEM.
mem_wr  in  1  the MEM instruction writes the register file.
ex_br_taken  in  1  the branch/jump in EX resolved taken.
pc_en  out  1  PC register load enable.
pc_sel  out  1  1 = load the branch target, 0 = load PC+4.
if_id_en  out  1  IF/ID register load enable.
if_id_flush  out  1  IF/ID register loads a NOP.
id_ex_bubble  out  1  ID/EX register loads a NOP (all control bits cleared).
busy  out  1  the controller is in RUN or DRAIN.
done  out  1  one-cycle pulse when a halt retires.
stall_cnt  out  CNT_W  total RAW-stall cycles since start; saturates.
flush_cnt  out  CNT_W  total taken-branch flushes since start; saturates.

Behaviour:
- State machine: IDLE, RUN, DRAIN, DONE. The state register and counters are registered. The control outputs are combinational from the state and the current-cycle inputs.
- Reset (synchronous, active-high): state goes to IDLE. All outputs are 0 and both counters are 0. Reset dominates any other input in the same cycle.
- IDLE: pc_en, if_id_en, pc_sel, if_id_flush, id_ex_bubble and busy are all 0. On start, go to RUN and clear both counters.
- RUN, default cycle: pc_en=1, if_id_en=1, pc_sel=0, if_id_flush=0, id_ex_bubble=0, busy=1.
- RAW hazard condition (haz):
  - The EX writer matches: ex_wr=1, ex_dest≠0, and ex_dest equals id_rs, or equals id_rt with id_uses_rt=1.
  - Or the MEM writer matches under the same rules using mem_wr and mem_dest.
- WB is not checked: the register file writes first and reads after in the same cycle.
- Register 0 never causes a hazard.
- RUN with haz and no ex_br_taken: pc_en=0, if_id_en=0, id_ex_bubble=1. stall_cnt increments. A single hazard costs at most 2 cycles, after which the writer has left MEM.
- RUN with ex_br_taken: pc_en=1, pc_sel=1, if_id_flush=1, id_ex_bubble=1. flush_cnt increments.
  - Branch has priority over haz, because the hazarded instruction is squashed.
  - Branch has priority over id_halt; the younger halt is squashed and the state stays RUN.
- RUN with id_halt, no haz and no ex_br_taken:
  - pc_en=0 and if_id_flush=1, so the halt is not re-decoded; id_ex_bubble=0, so the halt proceeds.
  - Load the drain counter with DRAIN_CYC and go to DRAIN.
- RUN with id_halt and haz together: stall as normal. The halt is evaluated again once haz clears.
- DRAIN: pc_en=0, if_id_en=0, if_id_flush=1, id_ex_bubble=1, busy=1. The counter decrements each cycle; at 1, go to DONE. ex_br_taken is ignored in DRAIN, because no older branch can exist.
- DONE: done=1 for exactly one cycle, busy=0, all enables 0; go to IDLE.
- start outside IDLE is ignored.
- Counters saturate at 2^CNT_W−1 and are held in IDLE until the next start. A reset in the middle of RUN or DRAIN returns to IDLE with no done pulse.
- Latency: stall and flush decisions take effect at the same-cycle clock edge; halt-to-done takes DRAIN_CYC+1 cycles after the halt is seen in ID.

Decomposition:
- Shared package: typedef enum pipe_ctrl_state_e {IDLE, RUN, DRAIN, DONE}; constant REG_ZERO=0; DRAIN_CYC default.
- One sub-module, raw_detect: a purely combinational comparator taking id_rs/id_rt/id_uses_rt and one writer's (dest, wr) pair, giving a match output. It is instantiated twice, once for EX and once for MEM. The FSM and counters stay in pipe_ctrl.

Test Plan:
- Reset, then start, with no hazards for 10 cycles → busy=1, pc_en=1 every cycle, stall_cnt=0, flush_cnt=0.
- ex_wr=1, ex_dest=5, id_rs=5 for 1 cycle, then mem_wr=1, mem_dest=5 for 1 cycle → 2 cycles of pc_en=0, id_ex_bubble=1; stall_cnt=2.
- ex_dest=0, ex_wr=1, id_rs=0 → no stall. Match on id_rt=7 with id_uses_rt=0 → no stall.
- ex_br_taken=1 together with a haz and id_halt → pc_sel=1, if_id_flush=1, id_ex_bubble=1; stall_cnt unchanged, flush_cnt=1, state stays RUN.
- id_halt=1 in a clean cycle → DRAIN for 3 cycles, then a done pulse 4 cycles after the halt, then IDLE with all enables 0.
- reset asserted during the 2nd DRAIN cycle → IDLE next edge, no done pulse, counters 0; a following start → RUN.
